mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the native valid/ready memory bus (mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata) in the SoC top.
- Master 0 is the CPU; master 1 is a DMA/boot-loader port.
- Shares the single memory/peripheral bus with round-robin fairness and a transaction lock.
- A watchdog terminates transactions the slave never acknowledges, so neither master hangs.

---
 rtl/soc_bus_pkg.sv | 19 +
 rtl/rr_pick2.sv | 12 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the native valid/ready memory bus.
package soc_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] wstrb;
  } mem_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on a tie the master that did not win last time wins.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_any
);

  assign o_any    = |i_req;
  assign o_winner = (i_req[0] & i_req[1]) ? ~i_last_grant : i_req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter for the native memory bus with round-robin
// fairness, a lock for the duration of a transaction and a no-ack watchdog.
module mem_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic                grant,
  output logic                busy,
  output logic                err
);

  localparam int unsigned SW   = DATA_W / 8;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  arb_state_e    r_state;
  logic          r_last_grant;
  logic [TW-1:0] r_timer;

  logic              w_win, w_any;
  logic              w_live, w_tmo_hit, w_done;
  logic [DATA_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [SW-1:0]     w_wstrb;

  rr_pick2 u_pick (
    .i_req        ({m1_valid, m0_valid}),
    .i_last_grant (r_last_grant),
    .o_winner     (w_win),
    .o_any        (w_any)
  );

  assign w_addr  = w_win ? m1_addr  : m0_addr;
  assign w_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_wstrb = w_win ? m1_wstrb : m0_wstrb;

  // Completion is suppressed in a reset cycle so an aborted transfer never acks.
  assign w_live    = (r_state == BUSY) && !reset;
  assign w_tmo_hit = (r_timer == TMAX);
  assign w_done    = w_live && (s_ready || w_tmo_hit);
  assign w_rd      = s_ready ? s_rdata : ERR_RDATA;

  assign m0_ready = w_done && !grant;
  assign m1_ready = w_done &&  grant;
  assign m0_rdata = m0_ready ? w_rd : '0;
  assign m1_rdata = m1_ready ? w_rd : '0;
  assign err      = w_live && !s_ready && w_tmo_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_timer      <= '0;
      s_valid      <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_wstrb      <= '0;
      grant        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BUSY;
            grant   <= w_win;
            s_addr  <= w_addr;
            s_wdata <= w_wdata;
            s_wstrb <= w_wstrb;
            s_valid <= 1'b1;
            busy    <= 1'b1;
            r_timer <= '0;
          end
        end
        BUSY: begin
          if (s_ready || w_tmo_hit) begin
            r_state      <= IDLE;
            s_valid      <= 1'b0;
            busy         <= 1'b0;
            r_last_grant <= grant;
            r_timer      <= '0;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset-abort
// sequence and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  import soc_bus_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        m0_ready, m1_ready, s_valid, grant, busy, err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy), .err(err)
  );

  typedef struct {
    logic        v0, v1;
    mem_req_t    r0, r1;
    int          lat;   // BUSY cycle (1-based) in which the slave acks
    logic [31:0] rd;
    logic        eg;
    logic [31:0] erd;
    logic        eerr;
    logic        scr;   // scramble winner inputs during BUSY
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_req_t rq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s;
    return r;
  endfunction

  function automatic vec_t mk(input logic v0, input logic v1, input mem_req_t r0, input mem_req_t r1,
                              input int lat, input logic [31:0] rd, input logic eg,
                              input logic [31:0] erd, input logic eerr, input logic scr);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.r0 = r0; v.r1 = r1; v.lat = lat; v.rd = rd;
    v.eg = eg; v.erd = erd; v.eerr = eerr; v.scr = scr;
    return v;
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_svalid"}, 64'(s_valid), 64'd0);
    chk({nm, "_rdy"}, 64'({m0_ready, m1_ready}), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'd0);
    chk({nm, "_rdata"}, {m0_rdata, m1_rdata}, 64'd0);
  endtask

  // One IDLE cycle presenting the requests, then the BUSY phase to completion.
  task automatic txn(input vec_t v, input string nm);
    mem_req_t w;
    int lc;
    logic done;
    step();
    m0_valid = v.v0; {m0_addr, m0_wdata, m0_wstrb} = v.r0;
    m1_valid = v.v1; {m1_addr, m1_wdata, m1_wstrb} = v.r1;
    s_ready = 1'b1; s_rdata = $urandom();
    @(negedge clk);
    chk_idle({nm, "_idle"});
    if (!(v.v0 || v.v1)) return;
    w  = v.eg ? v.r1 : v.r0;
    lc = (v.lat <= TO) ? v.lat : TO;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (v.scr) begin
        if (v.eg) {m1_addr, m1_wdata, m1_wstrb} = {$urandom(), $urandom(), 4'($urandom_range(0, 15))};
        else      {m0_addr, m0_wdata, m0_wstrb} = {$urandom(), $urandom(), 4'($urandom_range(0, 15))};
      end
      s_ready = (i == v.lat);
      s_rdata = (i == v.lat) ? v.rd : $urandom();
      @(negedge clk);
      done = (i == lc);
      chk({nm, "_svalid"}, 64'(s_valid), 64'd1);
      chk({nm, "_busy"}, 64'(busy), 64'd1);
      chk({nm, "_grant"}, 64'(grant), 64'(v.eg));
      chk({nm, "_saddr"}, 64'(s_addr), 64'(w.addr));
      chk({nm, "_swdata"}, 64'(s_wdata), 64'(w.wdata));
      chk({nm, "_swstrb"}, 64'(s_wstrb), 64'(w.wstrb));
      chk({nm, "_m0rdy"}, 64'(m0_ready), 64'(done && !v.eg));
      chk({nm, "_m1rdy"}, 64'(m1_ready), 64'(done && v.eg));
      chk({nm, "_m0rdata"}, 64'(m0_rdata), (done && !v.eg) ? 64'(v.erd) : 64'd0);
      chk({nm, "_m1rdata"}, 64'(m1_rdata), (done && v.eg) ? 64'(v.erd) : 64'd0);
      chk({nm, "_err"}, 64'(err), 64'(done && v.eerr));
      if (done) break;
    end
  endtask

  mem_req_t z, pay[2];
  logic     pend[2];
  int       last, jd, win, lat;
  logic [31:0] rd;

  initial begin
    z = rq(32'h0, 32'h0, 4'h0);
    reset = 1'b1; s_ready = 1'b0; s_rdata = '0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    {m0_addr, m0_wdata, m0_wstrb} = z; {m1_addr, m1_wdata, m1_wstrb} = z;
    step(); step();
    @(negedge clk);
    chk_idle("rst");
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s", {s_addr, s_wdata} | 64'(s_wstrb), 64'd0);
    step(); reset = 1'b0;

    // Directed vectors; expected grant/rdata/err are hand-derived constants.
    tbl.push_back(mk(1, 1, rq(32'h0, 32'h0, 0), rq(32'h4, 32'h0, 0), 1, 32'hA0A0_0001, 0, 32'hA0A0_0001, 0, 0));
    tbl.push_back(mk(0, 1, rq(32'h0, 32'h0, 0), rq(32'h4, 32'h0, 0), 3, 32'hA0A0_0002, 1, 32'hA0A0_0002, 0, 0));
    tbl.push_back(mk(1, 0, rq(32'h100, 32'h0, 0), z, 2, 32'h1234_5678, 0, 32'h1234_5678, 0, 0));
    tbl.push_back(mk(0, 1, z, rq(32'h2000_0000, 32'hCAFE_F00D, 4'b0011), 4, 32'h55, 1, 32'h55, 0, 1));
    tbl.push_back(mk(1, 0, rq(32'h300, 32'h0, 0), z, 100, 32'h1111, 0, 32'hDEAD_BEEF, 1, 0));
    tbl.push_back(mk(0, 1, z, rq(32'h304, 32'h0, 0), 8, 32'h77, 1, 32'h77, 0, 0));
    tbl.push_back(mk(1, 0, rq(32'h10, 32'h0, 0), z, 1, 32'h10, 0, 32'h10, 0, 0));
    tbl.push_back(mk(0, 0, z, z, 1, 32'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, rq(32'h20, 32'h0, 0), rq(32'h24, 32'h0, 0), 2, 32'h24, 1, 32'h24, 0, 0));
    tbl.push_back(mk(1, 0, rq(32'h20, 32'h0, 0), z, 1, 32'h20, 0, 32'h20, 0, 0));
    tbl.push_back(mk(0, 0, z, z, 1, 32'h0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, rq(32'h30, 32'h0, 0), rq(32'h34, 32'h0, 0), 1, 32'h34, 1, 32'h34, 0, 0));
    tbl.push_back(mk(1, 0, rq(32'h30, 32'h0, 0), z, 5, 32'h30, 0, 32'h30, 0, 0));
    tbl.push_back(mk(0, 0, z, z, 1, 32'h0, 0, 32'h0, 0, 0));
    foreach (tbl[i]) txn(tbl[i], $sformatf("vec%0d", i));

    // Reset in the 2nd BUSY cycle: no ack, then a tie must go back to M0.
    step(); m0_valid = 1'b1; m0_addr = 32'h60; m1_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk); chk("ra_idle_busy", 64'(busy), 64'd0);
    step();
    @(negedge clk); chk("ra_busy1", 64'(s_valid), 64'd1);
    step(); reset = 1'b1; s_ready = 1'b1; s_rdata = 32'h99;
    @(negedge clk);
    chk("ra_rdy", 64'({m0_ready, m1_ready}), 64'd0);
    chk("ra_err", 64'(err), 64'd0);
    chk("ra_rdata", {m0_rdata, m1_rdata}, 64'd0);
    step(); reset = 1'b0; m0_valid = 1'b0; s_ready = 1'b0;
    @(negedge clk); chk_idle("ra_after");
    txn(mk(1, 1, rq(32'h70, 32'h1, 1), rq(32'h74, 32'h2, 2), 2, 32'h70, 0, 32'h70, 0, 0), "ra_tie0");
    txn(mk(0, 1, rq(32'h70, 32'h1, 1), rq(32'h74, 32'h2, 2), 1, 32'h74, 1, 32'h74, 0, 0), "ra_tie1");

    // Randomized traffic; model tracks pending requests and round-robin history.
    last = 1; jd = 1; pend[0] = 1'b0; pend[1] = 1'b0; pay[0] = z; pay[1] = z;
    for (int t = 0; t < 60; t++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && m != jd && $urandom_range(0, 2) != 0) begin
          pend[m] = 1'b1;
          pay[m]  = rq($urandom(), $urandom(), 4'($urandom_range(0, 15)));
        end
      if (!pend[0] && !pend[1]) begin
        txn(mk(0, 0, pay[0], pay[1], 1, 32'h0, 0, 32'h0, 0, 0), "rnd_idle");
        jd = -1;
        continue;
      end
      win = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
      lat = $urandom_range(1, 10);
      rd  = $urandom();
      txn(mk(pend[0], pend[1], pay[0], pay[1], lat, rd, 1'(win),
             (lat <= TO) ? rd : 32'hDEAD_BEEF, lat > TO, 1'($urandom_range(0, 1))),
          $sformatf("rnd%0d", t));
      pend[win] = 1'b0; last = win; jd = win;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
